seg_display_mux: RTL
====================

Name: seg_display_mux

Overview:
Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the game core logic and drives the board's an/seg pins. It converts four 4-bit hex digit values plus per-digit blank and blink masks into active-low anode and segment signals. It uses a refresh scan counter, a blink timer, anti-ghosting guard slots and frame-boundary shadow latching, so the displayed values never tear mid-frame.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal values are ≥ 2.
GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
BLINK_DIV, 25000000, clock cycles per blink phase toggle (2 Hz blink at 100 MHz); legal values are ≥ 1.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
digits  input  16  hex digit values; digits[3:0] = digit 0 (rightmost, an[0]) … digits[15:12] = digit 3
blank_mask  input  4  bit i = 1: digit i is dark
blink_mask  input  4  bit i = 1: digit i is dark during the blink-off phase
an  output  4  anode enables, active-low, registered
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered

Behaviour:
- Reset behaviour (rst high, applied asynchronously):
  - an = 4'b1111, seg = 7'b1111111.
  - refresh counter = 0, digit index = 0, blink counter = 0, blink_on = 1.
  - Shadow registers: digits = 0, blank = 4'hF, blink = 0.
  - load_pending = 1.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. On wrap, the index advances 0→1→2→3→0.
- Shadow load: shadow registers capture digits, blank_mask and blink_mask on either event:
  - the cycle where counter = REFRESH_DIV-1 and index = 3 (end of frame), or
  - the first clock edge after reset deasserts (load_pending set); load_pending then clears.
- Input changes at any other time have no effect until the next shadow load.
- Blink timer: counts 0..BLINK_DIV-1; on wrap, blink_on toggles.
- Output registers are updated every clock from the pre-edge counter, index, blink_on and shadow state (one-cycle latency).
  - If counter < GUARD_CYCLES: an = 1111, seg = 1111111.
  - Else, if shadow_blank[index] = 1, or (shadow_blink[index] = 1 and blink_on = 0): an = 1111, seg = 1111111.
  - Else: an = ~(4'b0001 << index), seg = hex decode of shadow digit[index].
- Blank takes priority over blink. Exactly one or zero anodes are low at any time.
- Hex decode (seg, {g..a} active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-slot: outputs go dark immediately, without waiting for a clock edge. After release, scanning restarts at digit 0, slot cycle 0.
- The blink timer is free-running and independent of frame boundaries.

Test Plan:
All scenarios use REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_DIV=64.
1. Hold rst high for 3 cycles, then release with digits=16'h1234, masks=0:
   - during reset: an=1111, seg=1111111;
   - first slot: an=1111 for 2 cycles, then an=1110, seg=0011001 ("4") for 6 cycles;
   - next slots: an=1101 "3" (0110000), an=1011 "2", an=0111 "1"; then the pattern repeats.
2. Change digits from 16'h1234 to 16'hABCD in the middle of the digit-1 slot:
   - digits 2 and 3 still show "2" and "1" for the rest of that frame;
   - the next frame shows an=1110 with seg=0100001 ("d").
3. Set blank_mask=4'b0101 with digits=16'h8888:
   - the an[0] and an[2] slots keep an=1111 for the full slot;
   - the an[1] and an[3] slots show seg=0000000.
4. Set blink_mask=4'b0001 and blank_mask=0:
   - digit 0 is visible for 64 cycles and dark for 64 cycles, alternating;
   - digits 1–3 are unaffected.
   Then set blank_mask=4'b0001 as well: digit 0 stays dark in both blink phases.
5. Assert rst asynchronously during the active part of the digit-2 slot:
   - an=1111 and seg=1111111 before the next clk edge;
   - after release, scanning starts with the digit-0 guard cycles.
6. Sweep digit 0 through values 0..F, one per frame: each value yields exactly the decode table entry above.

Source files
------------

// File: rtl/seg_display_mux.sv
// Time-multiplexed 4-digit seven-segment driver with guard slots, blink timer
// and frame-boundary shadow latching of the digit/mask inputs.

module seg_digit_lane (
  input  logic       blink_on,
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       blink,
  output logic       vis,
  output logic [6:0] seg
);
  always_comb begin
    // blank wins; blink only darkens the digit during the off phase
    vis = !blank && !(blink && !blink_on);
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end
endmodule

module seg_display_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  localparam int ND = 4;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD      = CW'(GUARD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef struct packed {
    logic [ND-1:0][3:0] dig;
    logic [ND-1:0]      blank;
    logic [ND-1:0]      blink;
  } shadow_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_on_q, blink_on_d;
  shadow_t       sh_q, sh_d;
  logic          pend_q, pend_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [ND-1:0]      lane_vis;
  logic [ND-1:0][6:0] lane_seg;

  for (genvar g = 0; g < ND; g++) begin : g_lane
    seg_digit_lane u_lane (
      .blink_on (blink_on_q),
      .nib      (sh_q.dig[g]),
      .blank    (sh_q.blank[g]),
      .blink    (sh_q.blink[g]),
      .vis      (lane_vis[g]),
      .seg      (lane_seg[g])
    );
  end

  logic slot_wrap, frame_end;

  always_comb begin
    slot_wrap  = (cnt_q == CNT_LAST);
    frame_end  = slot_wrap && (idx_q == 2'd3);

    cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d      = slot_wrap ? idx_q + 2'd1 : idx_q;

    bcnt_d     = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
    blink_on_d = (bcnt_q == BLINK_LAST) ? !blink_on_q : blink_on_q;

    // shadow only moves at frame end (or right after reset) so a frame never tears
    sh_d   = sh_q;
    pend_d = 1'b0;
    if (pend_q || frame_end) begin
      sh_d.dig   = digits;
      sh_d.blank = blank_mask;
      sh_d.blink = blink_mask;
    end

    an_d  = 4'hF;
    seg_d = 7'h7F;
    if (cnt_q >= GUARD && lane_vis[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = lane_seg[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      bcnt_q     <= '0;
      blink_on_q <= 1'b1;
      sh_q       <= '{dig: '0, blank: 4'hF, blink: 4'h0};
      pend_q     <= 1'b1;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      blink_on_q <= blink_on_d;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
endmodule
